controlador_display: RTL and testbench

Sequencing controller for the Gray-switch display datapath. Synchronizes and debounces the raw 4-bit Gray switch input and presents a stable code to `gray_to_binary`. Takes the converted binary value back, splits it into units and tens, and time-multiplexes a two-digit seven-segment display. It drives the shared `decodificador_siete` input and the active-low digit enables through a blanked scan FSM.

---
 rtl/controlador_display.sv | 139 +++++++++++++
 tb/tb_controlador_display.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/controlador_display.sv
// Switch debounce and two-digit seven-segment scan controller for the Gray-switch display path.
// Optional build macro LEADING_ZERO_BLANK_EN: blank the tens digit when it is zero.
module controlador_display #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int REFRESH_CYCLES  = 27000,
  parameter int BLANK_CYCLES    = 270
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] gray_in,
  output logic [3:0] gray_out,
  input  logic [3:0] bin_in,
  output logic       new_value,
  output logic [3:0] digit_val,
  output logic [1:0] anodo
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PMAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int PW = (PMAX > 2) ? $clog2(PMAX) : 1;

  // The accepting edge is the one on which the counter would reach DEBOUNCE_CYCLES-1.
  localparam logic [DW-1:0] DB_HIT   = DW'(DEBOUNCE_CYCLES - 2);
  localparam logic [PW-1:0] REF_LAST = PW'(REFRESH_CYCLES - 1);
  localparam logic [PW-1:0] BLK_LAST = PW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_BLANK2 = 2'd0,
    S_UNITS  = 2'd1,
    S_BLANK1 = 2'd2,
    S_TENS   = 2'd3
  } scan_state_t;

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    sync2_prev;
  logic [DW-1:0] db_cnt;

  scan_state_t   scan_state;
  logic [PW-1:0] phase;
  logic          phase_done;
  logic [3:0]    disp;

  function automatic logic [3:0] units_of(input logic [3:0] v);
    return (v >= 4'd10) ? (v - 4'd10) : v;
  endfunction

  function automatic logic [3:0] tens_of(input logic [3:0] v);
    return (v >= 4'd10) ? 4'd1 : 4'd0;
  endfunction

  // Input path: two-flop synchronizer, then a stability counter against the accepted code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 4'd0;
      sync2      <= 4'd0;
      sync2_prev <= 4'd0;
      db_cnt     <= '0;
      gray_out   <= 4'd0;
      new_value  <= 1'b0;
    end else begin
      sync1      <= gray_in;
      sync2      <= sync1;
      sync2_prev <= sync2;
      new_value  <= 1'b0;
      if (sync2 == gray_out) begin
        db_cnt <= '0;
      end else if (sync2 != sync2_prev) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_HIT) begin
        gray_out  <= sync2;
        new_value <= 1'b1;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    phase_done = 1'b0;
    case (scan_state)
      S_UNITS, S_TENS:   phase_done = (phase == REF_LAST);
      S_BLANK1, S_BLANK2: phase_done = (phase == BLK_LAST);
      default:           phase_done = 1'b1;
    endcase
  end

  // Scan FSM: disp is only loaded when leaving S_BLANK2 so a frame never mixes two values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_state <= S_BLANK2;
      phase      <= '0;
      disp       <= 4'd0;
      anodo      <= 2'b11;
      digit_val  <= 4'd0;
    end else if (!phase_done) begin
      phase <= phase + 1'b1;
    end else begin
      phase <= '0;
      case (scan_state)
        S_BLANK2: begin
          scan_state <= S_UNITS;
          disp       <= bin_in;
          anodo      <= 2'b10;
          digit_val  <= units_of(bin_in);
        end
        S_UNITS: begin
          scan_state <= S_BLANK1;
          anodo      <= 2'b11;
        end
        S_BLANK1: begin
          scan_state <= S_TENS;
`ifdef LEADING_ZERO_BLANK_EN
          if (tens_of(disp) == 4'd0) begin
            anodo     <= 2'b11;
            digit_val <= 4'd0;
          end else begin
            anodo     <= 2'b01;
            digit_val <= tens_of(disp);
          end
`else
          anodo      <= 2'b01;
          digit_val  <= tens_of(disp);
`endif
        end
        S_TENS: begin
          scan_state <= S_BLANK2;
          anodo      <= 2'b11;
        end
        default: begin
          scan_state <= S_BLANK2;
          anodo      <= 2'b11;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_display.sv
// Directed bench for controlador_display with a behavioural Gray-to-binary converter in the loop.
module tb_controlador_display;

  logic       clk;
  logic       rst;
  logic [3:0] gray_in;
  logic [3:0] gray_out;
  logic [3:0] bin_in;
  logic       new_value;
  logic [3:0] digit_val;
  logic [1:0] anodo;

  int total = 0;
  int bad   = 0;
  int e     = 0;
  int pulses = 0;
  logic [3:0] exp_gray = 4'd0;
  int exp_disp = 0;
  int exp_dv   = 0;
  logic [1:0] exp_an = 2'b11;

  controlador_display #(
    .DEBOUNCE_CYCLES(4),
    .REFRESH_CYCLES (8),
    .BLANK_CYCLES   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .gray_in  (gray_in),
    .gray_out (gray_out),
    .bin_in   (bin_in),
    .new_value(new_value),
    .digit_val(digit_val),
    .anodo    (anodo)
  );

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  assign bin_in = g2b(gray_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock edge; checks anodo/digit_val against a frame-position model of the scan.
  task automatic step();
    int p;
    @(posedge clk);
    #1;
    e++;
    if (new_value === 1'b1) pulses++;
    if (e >= 2) begin
      p = (e - 2) % 20;
      if (p == 0) begin
        exp_disp = int'(g2b(exp_gray));
        exp_dv   = exp_disp % 10;
      end
      if (p == 10) exp_dv = exp_disp / 10;
      if (p < 8) exp_an = 2'b10;
      else if (p < 10) exp_an = 2'b11;
      else if (p < 18) begin
`ifdef LEADING_ZERO_BLANK_EN
        exp_an = (exp_disp / 10 == 0) ? 2'b11 : 2'b01;
`else
        exp_an = 2'b01;
`endif
      end
      else exp_an = 2'b11;
    end else begin
      exp_an = 2'b11;
    end
    chk($sformatf("anodo@%0d", e), {6'd0, anodo}, {6'd0, exp_an});
    chk($sformatf("digit_val@%0d", e), {4'd0, digit_val}, 8'(exp_dv));
  endtask

  initial begin
    rst     = 1'b1;
    gray_in = 4'b0000;
    #1;
    chk("rst_gray_out", {4'd0, gray_out}, 8'h00);
    chk("rst_new_value", {7'd0, new_value}, 8'h00);
    chk("rst_digit_val", {4'd0, digit_val}, 8'h00);
    chk("rst_anodo", {6'd0, anodo}, 8'h03);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_anodo", {6'd0, anodo}, 8'h03);
    rst     = 1'b0;
    gray_in = 4'b1011;

    // Clean change to 1011 (binary 13)
    repeat (5) step();
    chk("clean_gray_out_e5", {4'd0, gray_out}, 8'h00);
    chk("clean_new_value_e5", {7'd0, new_value}, 8'h00);
    step();
    chk("clean_gray_out_e6", {4'd0, gray_out}, 8'h0b);
    chk("clean_new_value_e6", {7'd0, new_value}, 8'h01);
    exp_gray = 4'b1011;
    step();
    chk("clean_new_value_e7", {7'd0, new_value}, 8'h00);
    while (e < 40) begin
      step();
      if (e == 22) begin
        chk("clean_units_digit", {4'd0, digit_val}, 8'h03);
        chk("clean_units_anodo", {6'd0, anodo}, 8'h02);
      end
      if (e == 32) begin
        chk("clean_tens_digit", {4'd0, digit_val}, 8'h01);
        chk("clean_tens_anodo", {6'd0, anodo}, 8'h01);
      end
    end
    chk("clean_pulse_count", 8'(pulses), 8'h01);

    // Bounce: toggle every 2 cycles for 20 cycles, then hold 0001
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      gray_in = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      step();
      step();
    end
    chk("bounce_no_pulse", 8'(pulses), 8'h00);
    gray_in = 4'b0001;
    repeat (5) step();
    chk("bounce_gray_out_e65", {4'd0, gray_out}, 8'h0b);
    chk("bounce_new_value_e65", {7'd0, new_value}, 8'h00);
    step();
    chk("bounce_gray_out_e66", {4'd0, gray_out}, 8'h01);
    chk("bounce_new_value_e66", {7'd0, new_value}, 8'h01);
    exp_gray = 4'b0001;
    pulses = 0;
    while (e < 98) begin
      step();
      if (e == 92) begin
        chk("value1_tens_digit", {4'd0, digit_val}, 8'h00);
      end
    end

    // Tear-free: gray_out changes to 0111 (binary 5) at edge 104, mid-S_UNITS
    gray_in = 4'b0111;
    repeat (5) step();
    step();
    chk("tear_gray_out_e104", {4'd0, gray_out}, 8'h07);
    chk("tear_new_value_e104", {7'd0, new_value}, 8'h01);
    exp_gray = 4'b0111;
    step();
    chk("tear_units_hold_digit", {4'd0, digit_val}, 8'h01);
    chk("tear_units_hold_anodo", {6'd0, anodo}, 8'h02);
    while (e < 135) begin
      step();
      if (e == 112) chk("tear_old_tens", {4'd0, digit_val}, 8'h00);
      if (e == 122) begin
        chk("scan_units_digit5", {4'd0, digit_val}, 8'h05);
        chk("scan_units_anodo5", {6'd0, anodo}, 8'h02);
      end
      if (e == 132) begin
`ifdef LEADING_ZERO_BLANK_EN
        chk("macro_tens_anodo", {6'd0, anodo}, 8'h03);
`else
        chk("macro_tens_anodo", {6'd0, anodo}, 8'h01);
`endif
        chk("macro_tens_digit", {4'd0, digit_val}, 8'h00);
      end
    end
    chk("tear_pulse_count", 8'(pulses), 8'h01);

    // Asynchronous reset in the middle of S_TENS
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_anodo", {6'd0, anodo}, 8'h03);
    chk("midrst_gray_out", {4'd0, gray_out}, 8'h00);
    chk("midrst_new_value", {7'd0, new_value}, 8'h00);
    chk("midrst_digit_val", {4'd0, digit_val}, 8'h00);
    #2;
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
